// File: rtl/seq_pkg.sv
// Shared sizes, FSM states and the level clamp for the sequence presenter.
package seq_pkg;

  localparam int SYM_W   = 4;
  localparam int NUM_SYM = 5;
  localparam int SEQ_W   = 20;
  localparam int LVL_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    DONE
  } state_t;

  // A level of zero still shows one symbol; anything past five shows all five.
  function automatic logic [LVL_W-1:0] clamp_len(input logic [LVL_W-1:0] lvl);
    if (lvl == '0)
      return LVL_W'(1);
    else if (lvl > LVL_W'(NUM_SYM))
      return LVL_W'(NUM_SYM);
    else
      return lvl;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11; steps every cycle.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= SEED;
    else
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/seq_presenter.sv
// Sequence game generator: draws a 5-symbol one-hot sequence and flashes
// the first LVL symbols on led with fixed on/off timing.
module seq_presenter
  import seq_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 50_000_000,
  parameter int unsigned OFF_CYCLES = 25_000_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             replay,
  input  logic [LVL_W-1:0] LVL,
  output logic [SEQ_W-1:0] Sequence,
  output logic             newSequence,
  output logic [SYM_W-1:0] led,
  output logic             display_done,
  output logic             busy
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int          TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [2:0]         idx;
  logic [LVL_W-1:0]   len;
  logic [15:0]        lfsr_q;
  logic               lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low ten LFSR bits pick symbols; the rest just keep the register busy.
  assign lfsr_unused = ^lfsr_q[15:10];

  // Outputs are driven from the state held during the previous cycle, so every
  // output is a flop and led cannot glitch between symbols.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      len          <= '0;
      Sequence     <= '0;
      newSequence  <= 1'b0;
      led          <= '0;
      display_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      newSequence  <= 1'b0;
      display_done <= 1'b0;
      led          <= '0;
      busy         <= (state != IDLE);
      case (state)
        IDLE: begin
          timer <= '0;
          idx   <= '0;
          if (start) begin
            len   <= clamp_len(LVL);
            state <= GEN;
          end else if (replay) begin
            len   <= clamp_len(LVL);
            state <= SHOW_ON;
          end
        end
        GEN: begin
          for (int i = 0; i < NUM_SYM; i++)
            Sequence[SYM_W*i +: SYM_W] <= SYM_W'(1) << lfsr_q[2*i +: 2];
          newSequence <= 1'b1;
          state       <= SHOW_ON;
        end
        SHOW_ON: begin
          led <= Sequence[SYM_W*idx +: SYM_W];
          if (timer == ON_LAST) begin
            timer <= '0;
            state <= SHOW_OFF;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SHOW_OFF: begin
          if (timer == OFF_LAST) begin
            timer <= '0;
            if (idx == len - 3'd1) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= SHOW_ON;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          display_done <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
